// File: rtl/vga_fb_pkg.sv
// Shared types and default VGA timing for the framebuffer scan-out arbiter.
package vga_fb_pkg;

    localparam int DEF_X_START = 112;
    localparam int DEF_Y_START = 13;
    localparam int DEF_H_ACT   = 640;
    localparam int DEF_V_ACT   = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } arb_state_e;

endpackage

// File: rtl/vga_fb_scanout_arbiter_fifo.sv
// Prefetch FIFO for scan-out pixels; flush wins over a simultaneous push or pop.
module fb_prefetch_fifo
    import vga_fb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [23:0]   wdata,
    output logic [23:0]   head,
    output logic [PW:0]   count,
    output logic          empty
);

    rgb_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_push = push && !flush && (count != (PW+1)'(DEPTH));
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= rgb_t'(wdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: scan-out prefetch has strict priority over processor writes.
// Optional sticky underrun flag built only when VGA_FB_UNDERRUN_FLAG_EN is defined.
//
//  state (registered op of previous cycle) | meaning
//  IDLE  | no RAM operation issued
//  FETCH | scan-out read issued; its data arrives on iMEM_RDATA this cycle
//  WRITE | processor write issued
module vga_fb_scanout_arbiter
    import vga_fb_pkg::*;
#(
    parameter  int X_START    = DEF_X_START,
    parameter  int Y_START    = DEF_Y_START,
    parameter  int H_ACT      = DEF_H_ACT,
    parameter  int V_ACT      = DEF_V_ACT,
    parameter  int SCALE_LOG2 = 2,
    parameter  int FIFO_DEPTH = 8,
    localparam int FB_W       = H_ACT >> SCALE_LOG2,
    localparam int FB_H       = V_ACT >> SCALE_LOG2,
    localparam int FB_SIZE    = FB_W * FB_H,
    localparam int AW         = $clog2(FB_SIZE)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [9:0]    iH_Cont,
    input  logic [9:0]    iV_Cont,
    output logic [AW-1:0] oMEM_ADDR,
    output logic          oMEM_WE,
    output logic [23:0]   oMEM_WDATA,
    input  logic [23:0]   iMEM_RDATA,
    input  logic          iWR_VALID,
    input  logic [AW-1:0] iWR_ADDR,
    input  logic [23:0]   iWR_DATA,
    output logic          oWR_READY,
    output logic [7:0]    oRed,
    output logic [7:0]    oGreen,
    output logic [7:0]    oBlue,
    output logic          oUNDERRUN
);

    localparam int        PW      = $clog2(FIFO_DEPTH);
    localparam int        CW      = $clog2(FB_W + 1);
    localparam int        SW      = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [9:0] X_LO   = 10'(X_START);
    localparam logic [9:0] X_HI   = 10'(X_START + H_ACT);
    localparam logic [9:0] Y_LO   = 10'(Y_START);
    localparam logic [9:0] Y_HI   = 10'(Y_START + V_ACT);

    arb_state_e    state_q;
    arb_state_e    op;
    logic [CW-1:0] fetch_col;
    logic [AW-1:0] row_base;
    logic [AW-1:0] row_sel;
    logic [AW-1:0] fetch_addr;
    logic [9:0]    v_off;
    logic [SW-1:0] sub;
    logic          starved;
    logic          active_line;
    logic          line_start;
    logic          frame_start;
    logic          display;
    logic          group_end;
    logic          fetch_needed;
    logic [PW+1:0] fill;
    logic [PW:0]   fifo_count;
    logic          fifo_empty;
    logic [23:0]   fifo_head;
    rgb_t          pix;

    assign active_line = (iV_Cont >= Y_LO) && (iV_Cont < Y_HI);
    assign line_start  = active_line && (iH_Cont == '0);
    assign frame_start = (iV_Cont == '0) && (iH_Cont == '0);
    assign display     = active_line && (iH_Cont >= X_LO) && (iH_Cont < X_HI);
    assign group_end   = display && (sub == SUB_MAX);

    assign v_off      = iV_Cont - Y_LO;
    assign row_sel    = AW'(v_off >> SCALE_LOG2);
    assign fetch_addr = row_base + AW'(fetch_col);

    // An outstanding read still occupies a FIFO slot; the line-start cycle never fetches
    // because its data would land on the freshly flushed FIFO with the old row.
    assign fill         = (PW+2)'(fifo_count) + (PW+2)'(state_q == FETCH);
    assign fetch_needed = !line_start && (fetch_col < CW'(FB_W)) &&
                          (fill < (PW+2)'(FIFO_DEPTH));

    always_comb begin
        op         = IDLE;
        oMEM_ADDR  = '0;
        oMEM_WE    = 1'b0;
        oMEM_WDATA = '0;
        oWR_READY  = 1'b0;
        if (!iRST) begin
            if (fetch_needed)   op = FETCH;
            else if (iWR_VALID) op = WRITE;
        end
        case (op)
            FETCH: oMEM_ADDR = fetch_addr;
            WRITE: begin
                oMEM_ADDR  = iWR_ADDR;
                oMEM_WE    = (iWR_ADDR < AW'(FB_SIZE));
                oMEM_WDATA = iWR_DATA;
                oWR_READY  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            fetch_col <= '0;
            row_base  <= '0;
            sub       <= '0;
            starved   <= 1'b0;
        end else begin
            state_q <= op;
            if (line_start) begin
                fetch_col <= '0;
                row_base  <= row_sel * AW'(FB_W);
            end else if (op == FETCH) begin
                fetch_col <= fetch_col + 1'b1;
            end
            // A group that saw an empty FIFO stays black; its pixel is still consumed at group end.
            if (display) begin
                sub     <= (sub == SUB_MAX) ? '0 : sub + 1'b1;
                starved <= (sub == SUB_MAX) ? 1'b0 : (starved | fifo_empty);
            end else begin
                sub     <= '0;
                starved <= 1'b0;
            end
        end
    end

    fb_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (iCLK),
        .rst   (iRST),
        .push  (state_q == FETCH),
        .pop   (group_end),
        .flush (line_start),
        .wdata (iMEM_RDATA),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        pix = '0;
        if (display && !fifo_empty && !starved) pix = rgb_t'(fifo_head);
    end

    assign oRed   = pix.r;
    assign oGreen = pix.g;
    assign oBlue  = pix.b;

`ifdef VGA_FB_UNDERRUN_FLAG_EN
    logic underrun_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)                          underrun_q <= 1'b0;
        else if (frame_start)              underrun_q <= 1'b0;
        else if (display && fifo_empty)    underrun_q <= 1'b1;
    end

    assign oUNDERRUN = underrun_q;
`else
    assign oUNDERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_scanout_arbiter.sv
// Directed bench: ramp framebuffer, pixel probes from a vector table plus reset/write/stall sequences.
`timescale 1ns/1ps
module tb_vga_fb_scanout_arbiter;

    localparam int AW      = 15;
    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int H_TOT   = 760;
`ifdef VGA_FB_UNDERRUN_FLAG_EN
    localparam logic UF = 1'b1;
`else
    localparam logic UF = 1'b0;
`endif

    typedef struct {
        int          dut;
        int          v;
        int          h;
        logic [23:0] rgb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    h_cont = '0;
    logic [9:0]    v_cont = '0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;

    logic [AW-1:0] addr0, addr1;
    logic          we0, we1, rdy0, rdy1, und0, und1;
    logic [23:0]   wdata0, wdata1;
    logic [23:0]   rdata0 = '0, rdata1 = '0;
    logic [7:0]    r0, g0, b0, r1, g1, b1;
    logic [23:0]   ram0 [FB_SIZE];
    logic [23:0]   ram1 [FB_SIZE];

    int   n_checks = 0;
    int   n_pass = 0;
    int   hits = 0;
    int   bad_groups = 0;
    int   grp_ready = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    vga_fb_scanout_arbiter u_dut (
        .iCLK(clk), .iRST(rst), .iH_Cont(h_cont), .iV_Cont(v_cont),
        .oMEM_ADDR(addr0), .oMEM_WE(we0), .oMEM_WDATA(wdata0), .iMEM_RDATA(rdata0),
        .iWR_VALID(wr_valid), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data), .oWR_READY(rdy0),
        .oRed(r0), .oGreen(g0), .oBlue(b0), .oUNDERRUN(und0)
    );

    vga_fb_scanout_arbiter #(.X_START(2)) u_dut_x2 (
        .iCLK(clk), .iRST(rst), .iH_Cont(h_cont), .iV_Cont(v_cont),
        .oMEM_ADDR(addr1), .oMEM_WE(we1), .oMEM_WDATA(wdata1), .iMEM_RDATA(rdata1),
        .iWR_VALID(wr_valid), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data), .oWR_READY(rdy1),
        .oRed(r1), .oGreen(g1), .oBlue(b1), .oUNDERRUN(und1)
    );

    initial begin
        for (int row = 0; row < FB_H; row++)
            for (int col = 0; col < FB_W; col++) begin
                ram0[row*FB_W + col] = {8'(col), 8'(row), 8'h55};
                ram1[row*FB_W + col] = {8'(col), 8'(row), 8'h55};
            end
    end

    always @(posedge clk) begin
        if (we0) ram0[addr0] <= wdata0;
        rdata0 <= (int'(addr0) < FB_SIZE) ? ram0[addr0] : 24'h0;
        if (we1) ram1[addr1] <= wdata1;
        rdata1 <= (int'(addr1) < FB_SIZE) ? ram1[addr1] : 24'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input int d, input int vv, input int hh, input logic [23:0] rgb);
        vec_t e;
        e.dut = d; e.v = vv; e.h = hh; e.rgb = rgb;
        tbl.push_back(e);
    endfunction

    // mode 1: mid-line reset, 2: blanking writes, 3: writes held during prefetch
    task automatic run_line(input int vv, input int mode);
        for (int hh = 0; hh < H_TOT; hh++) begin
            @(posedge clk); #1;
            h_cont = 10'(hh);
            v_cont = 10'(vv);
            if (mode == 1) begin
                rst      = (hh == 300 || hh == 301);
                wr_valid = (hh == 300 || hh == 301);
                wr_addr  = 15'd20000;
            end
            if (mode == 2) begin
                wr_valid = (hh == 20 || hh == 30);
                wr_addr  = (hh == 30) ? 15'd19200 : 15'd489;
                wr_data  = 24'hABCDEF;
            end
            if (mode == 3) begin
                wr_valid = 1'b1;
                wr_addr  = 15'd20000;
            end
            @(negedge clk);
            for (int i = 0; i < tbl.size(); i++)
                if (tbl[i].v == vv && tbl[i].h == hh) begin
                    hits++;
                    check($sformatf("pix d%0d v%0d h%0d", tbl[i].dut, vv, hh),
                          32'(tbl[i].dut == 1 ? {r1, g1, b1} : {r0, g0, b0}), 32'(tbl[i].rgb));
                end
            if (mode == 1 && hh == 300) begin
                check("rst_mid rgb", 32'({r0, g0, b0}), 32'h0);
                check("rst_mid we", 32'(we0), 32'h0);
                check("rst_mid ready", 32'(rdy0), 32'h0);
            end
            if (mode == 2 && hh == 20) begin
                check("wr we", 32'(we0), 32'h1);
                check("wr ready", 32'(rdy0), 32'h1);
                check("wr addr", 32'(addr0), 32'd489);
                check("wr data", 32'(wdata0), 32'hABCDEF);
            end
            if (mode == 2 && hh == 30) begin
                check("oob ready", 32'(rdy0), 32'h1);
                check("oob we", 32'(we0), 32'h0);
            end
            if (mode == 3 && hh >= 1 && hh <= 8)
                check($sformatf("prefetch ready h%0d", hh), 32'(rdy0), 32'h0);
            if (mode == 3 && hh == 9)
                check("ready after fill", 32'(rdy0), 32'h1);
            if (mode == 3 && hh >= 112 && hh < 752) begin
                grp_ready += int'(rdy0);
                if ((hh - 112) % 4 == 3) begin
                    if (grp_ready < 3) bad_groups++;
                    grp_ready = 0;
                end
            end
        end
        wr_valid = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        add(0, 100, 299, 24'h2E1555);
        add(0, 13, 112, 24'h000055);
        add(1, 13, 2, 24'h000000);
        add(1, 13, 5, 24'h000000);
        add(1, 13, 6, 24'h010055);
        add(1, 13, 10, 24'h020055);
        add(0, 25, 147, 24'h080355);
        add(0, 25, 148, 24'hABCDEF);
        add(0, 25, 151, 24'hABCDEF);
        add(0, 25, 152, 24'h0A0355);
        add(0, 33, 111, 24'h000000);
        add(0, 33, 139, 24'h060555);
        add(0, 33, 140, 24'h070555);
        add(0, 33, 141, 24'h070555);
        add(0, 33, 143, 24'h070555);
        add(0, 33, 144, 24'h080555);
        add(0, 33, 751, 24'h9F0555);
        add(0, 33, 752, 24'h000000);
        add(0, 492, 112, 24'h007755);
        add(0, 492, 751, 24'h9F7755);
        add(0, 493, 200, 24'h000000);

        wr_valid = 1'b1;
        wr_addr  = 15'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rgb", 32'({r0, g0, b0}), 32'h0);
        check("reset we", 32'(we0), 32'h0);
        check("reset ready", 32'(rdy0), 32'h0);
        check("reset addr", 32'(addr0), 32'h0);
        check("reset underrun", 32'(und0), 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        wr_valid = 1'b0;

        run_line(100, 1);
        check("underrun after mid reset", 32'(und0), 32'(UF));
        run_line(0, 2);
        check("ram written", 32'(ram0[489]), 32'hABCDEF);
        check("underrun cleared at frame", 32'(und0), 32'h0);
        run_line(13, 0);
        run_line(25, 0);
        run_line(33, 3);
        run_line(492, 0);
        run_line(493, 0);

        check("ready groups below 3 of 4", 32'(bad_groups), 32'h0);
        check("no underrun over frame", 32'(und0), 32'h0);
        check("starved dut underrun", 32'(und1), 32'(UF));
        check("probe hits", 32'(hits), 32'(tbl.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
